// File: rtl/pipe_ctrl_chain_if.sv
// Token, control and status bundle for pipe_ctrl_chain.
// The slave modport is the chain's view; master is the upstream/controller view.
interface pipe_ctrl_chain_if #(
  parameter int STAGES = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int SEL_W = $clog2(STAGES + 1);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_dest;
  logic              in_wb_en;
  logic              in_mem_r_en;
  logic [ADDR_W-1:0] in_src1;
  logic [ADDR_W-1:0] in_src2;
  logic [STAGES-1:0] stall_req;
  logic [STAGES-1:0] flush_req;
  logic              in_ready;
  logic              hazard;
  logic [SEL_W-1:0]  fwd_sel1;
  logic [SEL_W-1:0]  fwd_sel2;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_dest;
  logic              out_wb_en;
  logic [SEL_W-1:0]  occupancy;

  modport slave (
    input  in_valid, in_data, in_dest, in_wb_en, in_mem_r_en, in_src1, in_src2,
           stall_req, flush_req,
    output in_ready, hazard, fwd_sel1, fwd_sel2,
           out_valid, out_data, out_dest, out_wb_en, occupancy
  );

  modport master (
    output in_valid, in_data, in_dest, in_wb_en, in_mem_r_en, in_src1, in_src2,
           stall_req, flush_req,
    input  in_ready, hazard, fwd_sel1, fwd_sel2,
           out_valid, out_data, out_dest, out_wb_en, occupancy
  );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// Parametrised in-order pipeline register chain with per-stage freeze/flush,
// load-use / RAW hazard detection and forwarding-source selection.
module pipe_ctrl_chain #(
  parameter int STAGES = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit FWD_EN = 1'b1
) (
  input logic               clk,
  input logic               rst,
  pipe_ctrl_chain_if.slave  bus
);
  localparam int SEL_W = $clog2(STAGES + 1);
  localparam int LAST  = STAGES - 1;

  typedef struct packed {
    logic              v;
    logic              wb;
    logic              mr;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  logic [STAGES-1:0] frz;
  logic [STAGES-1:0] flush_mask;
  logic [STAGES-1:0] m1;
  logic [STAGES-1:0] m2;
  logic              haz;
  logic              ready;
  logic              accept;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    logic acc_s;
    logic acc_f;
    acc_s      = 1'b0;
    acc_f      = 1'b0;
    frz        = '0;
    flush_mask = '0;
    // A stall/flush at stage j reaches every younger stage 0..j.
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc_s         = acc_s | bus.stall_req[k];
      acc_f         = acc_f | bus.flush_req[k];
      frz[k]        = acc_s;
      flush_mask[k] = acc_f;
    end
  end

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < STAGES; k++) begin
      m1[k] = st_q[k].v & st_q[k].wb & (st_q[k].dest == bus.in_src1) &
              (bus.in_src1 != '0) & bus.in_valid;
      m2[k] = st_q[k].v & st_q[k].wb & (st_q[k].dest == bus.in_src2) &
              (bus.in_src2 != '0) & bus.in_valid;
    end
  end

  always_comb begin
    haz          = 1'b0;
    bus.fwd_sel1 = '0;
    bus.fwd_sel2 = '0;
    if (FWD_EN) begin
      haz = (m1[0] | m2[0]) & st_q[0].mr;
      // Scan oldest to youngest so the youngest producer overwrites last.
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (m1[k]) bus.fwd_sel1 = SEL_W'(k + 1);
        if (m2[k]) bus.fwd_sel2 = SEL_W'(k + 1);
      end
    end else begin
      haz = (|m1) | (|m2);
    end
  end

  assign ready      = rst & ~frz[0] & ~haz & ~(|bus.flush_req);
  assign accept     = bus.in_valid & ready;
  assign bus.hazard = haz;
  assign bus.in_ready = ready;

  always_comb begin
    for (int k = 0; k < STAGES; k++) st_d[k] = st_q[k];

    if (!frz[0]) begin
      if (accept) begin
        st_d[0] = '{v: 1'b1, wb: bus.in_wb_en, mr: bus.in_mem_r_en,
                    dest: bus.in_dest, data: bus.in_data};
      end else begin
        st_d[0].v  = 1'b0;
        st_d[0].wb = 1'b0;
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (!frz[k]) begin
        if (frz[k-1]) begin
          st_d[k].v  = 1'b0;
          st_d[k].wb = 1'b0;
        end else begin
          st_d[k] = st_q[k-1];
        end
      end
    end

    // Flush beats freeze: payload stays, validity goes.
    for (int k = 0; k < STAGES; k++) begin
      if (flush_mask[k]) begin
        st_d[k].v  = 1'b0;
        st_d[k].wb = 1'b0;
      end
    end
  end

  // NOTE: payload registers are reset too, so outputs read zero throughout reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment only.
      st_q <= st_d;
    end
  end

  always_comb begin
    bus.occupancy = '0;
    for (int k = 0; k < STAGES; k++) bus.occupancy = bus.occupancy + SEL_W'(st_q[k].v);
  end

  assign bus.out_valid = st_q[LAST].v;
  assign bus.out_data  = st_q[LAST].data;
  assign bus.out_dest  = st_q[LAST].dest;
  assign bus.out_wb_en = st_q[LAST].v & st_q[LAST].wb;
endmodule
